// File: rtl/firc_feeder.sv
// ============================================================================
//  Module      : firc_feeder
//  Description : Source-side driver for the firc complex FIR filter. Buffers
//                upstream I/Q samples in a FIFO, keeps a shadow coefficient
//                bank, and sequences coefficient loads so they never overlap
//                with sample pushes while honouring firc's StopIn.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module firc_feeder #(
    parameter int DEPTH = 8,
    parameter int NTAPS = 16
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        InValid,
    output logic        InReady,
    input  logic [23:0] InI,
    input  logic [23:0] InQ,
    input  logic        CfgWr,
    input  logic [4:0]  CfgAddr,
    input  logic [26:0] CfgI,
    input  logic [26:0] CfgQ,
    input  logic        CfgLoad,
    output logic        PushIn,
    output logic [23:0] SampI,
    output logic [23:0] SampQ,
    input  logic        StopIn,
    output logic        PushCoef,
    output logic [4:0]  CoefAddr,
    output logic [26:0] CoefI,
    output logic [26:0] CoefQ,
    output logic        Busy,
    output logic        LoadDone
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

    typedef enum logic [1:0] {
        S_WAIT_CFG = 2'd0,
        S_STREAM   = 2'd1,
        S_DRAIN    = 2'd2,
        S_LOAD     = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // Sample FIFO storage and bookkeeping
    logic [47:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    // Shadow coefficient bank
    logic [26:0]   r_sh_i [NTAPS];
    logic [26:0]   r_sh_q [NTAPS];

    // Registered firc-side outputs
    logic          r_push_in;
    logic [23:0]   r_samp_i;
    logic [23:0]   r_samp_q;
    logic          r_push_coef;
    logic [4:0]    r_coef_addr;
    logic [26:0]   r_coef_i;
    logic [26:0]   r_coef_q;
    logic          r_busy;
    logic          r_load_done;

    logic          w_accept;
    logic          w_consume;
    logic [CW-1:0] w_remain;
    logic [PW-1:0] w_rptr_nxt;
    logic          w_cfg_hit;
    logic          w_present;
    logic          w_push_in;
    logic          w_push_coef;
    logic [4:0]    w_coef_addr;
    logic          w_load_done;

    assign InReady    = (r_count < CW'(DEPTH));
    assign w_accept   = InValid & InReady;
    assign w_consume  = r_push_in & ~StopIn;
    // Entries left once the presented head is popped; the new head sits at rptr+pop
    assign w_remain   = r_count - CW'(w_consume);
    assign w_rptr_nxt = r_rptr + PW'(w_consume);
    assign w_cfg_hit  = CfgWr && (32'(CfgAddr) < 32'(NTAPS));

    assign PushIn   = r_push_in;
    assign SampI    = r_samp_i;
    assign SampQ    = r_samp_q;
    assign PushCoef = r_push_coef;
    assign CoefAddr = r_coef_addr;
    assign CoefI    = r_coef_i;
    assign CoefQ    = r_coef_q;
    assign Busy     = r_busy;
    assign LoadDone = r_load_done;

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= S_WAIT_CFG;
        else          r_state <= w_next;
    end

    // Next-state and next-output decode; LOAD state coincides with PushCoef=1
    always_comb begin
        w_next      = r_state;
        w_present   = 1'b0;
        w_push_in   = r_push_in & StopIn;   // a stalled sample is held, otherwise dropped
        w_push_coef = 1'b0;
        w_coef_addr = r_coef_addr;
        w_load_done = 1'b0;
        case (r_state)
            S_WAIT_CFG: begin
                if (CfgLoad) begin
                    w_next      = S_LOAD;
                    w_push_coef = 1'b1;
                    w_coef_addr = 5'd0;
                end
            end
            S_STREAM: begin
                if (CfgLoad) begin
                    w_next = S_DRAIN;
                end else if (!(r_push_in && StopIn) && (w_remain != '0)) begin
                    w_present = 1'b1;
                    w_push_in = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!r_push_in) begin
                    w_next      = S_LOAD;
                    w_push_coef = 1'b1;
                    w_coef_addr = 5'd0;
                end
            end
            S_LOAD: begin
                if (r_coef_addr == 5'(NTAPS - 1)) begin
                    w_next      = S_STREAM;
                    w_load_done = 1'b1;
                end else begin
                    w_push_coef = 1'b1;
                    w_coef_addr = r_coef_addr + 5'd1;
                end
            end
            default: w_next = S_WAIT_CFG;
        endcase
    end

    // FIFO pointers and occupancy; pop happens exactly on a consumed sample
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) r_wptr <= r_wptr + PW'(1);
            r_rptr  <= w_rptr_nxt;
            r_count <= r_count + CW'(w_accept) - CW'(w_consume);
        end
    end

    // FIFO data storage (contents are don't-care after reset)
    always_ff @(posedge Clk) begin
        if (w_accept) r_mem[r_wptr] <= {InI, InQ};
    end

    // Shadow bank writes; out-of-range addresses are dropped
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                r_sh_i[k] <= '0;
                r_sh_q[k] <= '0;
            end
        end else if (w_cfg_hit) begin
            r_sh_i[CfgAddr[AW-1:0]] <= CfgI;
            r_sh_q[CfgAddr[AW-1:0]] <= CfgQ;
        end
    end

    // firc-side output registers; the bank is sampled when a coefficient is pushed
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_push_in   <= 1'b0;
            r_samp_i    <= '0;
            r_samp_q    <= '0;
            r_push_coef <= 1'b0;
            r_coef_addr <= '0;
            r_coef_i    <= '0;
            r_coef_q    <= '0;
            r_busy      <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            r_push_in   <= w_push_in;
            if (w_present) begin
                r_samp_i <= r_mem[w_rptr_nxt][47:24];
                r_samp_q <= r_mem[w_rptr_nxt][23:0];
            end
            r_push_coef <= w_push_coef;
            r_coef_addr <= w_coef_addr;
            if (w_push_coef) begin
                r_coef_i <= r_sh_i[w_coef_addr[AW-1:0]];
                r_coef_q <= r_sh_q[w_coef_addr[AW-1:0]];
            end
            r_busy      <= (w_next != S_STREAM);
            r_load_done <= w_load_done;
        end
    end

endmodule

`default_nettype wire

// File: doc/firc_feeder.md
Name: firc_feeder

Overview:
- Source-side driver for the firc complex FIR filter. It is the transmitter for firc's sample input (PushIn/SampI/SampQ/StopIn) and coefficient input (PushCoef/CoefAddr/CoefI/CoefQ).
- It buffers upstream I/Q samples in a FIFO and holds a shadow coefficient bank.
- It sequences coefficient loads so they never interleave with sample pushes, and honours firc's StopIn backpressure.

Parameters:
- DEPTH, 8, sample FIFO entries (power of 2, >=2).
- NTAPS, 16, coefficients pushed per load (1..32); addresses are 0..NTAPS-1.

Ports:
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous active-low reset
- InValid  in  1  upstream sample valid
- InReady  out  1  upstream ready; transfer when InValid&InReady at posedge
- InI  in  24  sample I
- InQ  in  24  sample Q
- CfgWr  in  1  write shadow coefficient
- CfgAddr  in  5  shadow index; writes with CfgAddr>=NTAPS are ignored
- CfgI  in  27  coefficient I
- CfgQ  in  27  coefficient Q
- CfgLoad  in  1  one-cycle request to push the shadow bank into firc
- PushIn  out  1  to firc
- SampI  out  24  to firc
- SampQ  out  24  to firc
- StopIn  in  1  from firc; when high, a presented sample is not taken
- PushCoef  out  1  to firc
- CoefAddr  out  5  to firc
- CoefI  out  27  to firc
- CoefQ  out  27  to firc
- Busy  out  1  high in any state except STREAM
- LoadDone  out  1  one-cycle pulse after the last coefficient push

Behaviour:
- Reset (async assert, sync release): FIFO empty, shadow bank zeroed, state WAIT_CFG. All outputs 0 except InReady=1.
- Outputs: all firc-side outputs are registered. InReady = (count<DEPTH), taken from the registered count.
- FIFO accept: accepts in every state. Full: InReady=0 and InValid is ignored. Pointers wrap modulo DEPTH.
- Sample handshake: a sample is consumed at a posedge with PushIn=1 and StopIn=0.
  - While PushIn=1 and StopIn=1, PushIn, SampI and SampQ hold stable.
  - After a consumed sample, the next FIFO entry is presented in the following cycle if available (back-to-back, 1 sample/clk).
  - Otherwise PushIn drops to 0. SampI/SampQ keep their last value when PushIn=0.
- FIFO latency: sample enters at edge N, appears on PushIn at edge N+1 at earliest (FIFO empty, STREAM, PushIn=0).
- FIFO pop: pops exactly when the presented sample is consumed. Simultaneous accept and pop leaves the count unchanged.
- State machine:
  - WAIT_CFG: no sample push. CfgLoad -> LOAD.
  - STREAM: present samples as above. CfgLoad -> DRAIN.
  - DRAIN: no new sample presented. An outstanding PushIn stays held until consumed. When PushIn=0 -> LOAD (immediately if PushIn already 0).
  - LOAD: one coefficient per cycle, addr 0..NTAPS-1, PushCoef=1, shadow[addr] on CoefI/CoefQ. StopIn is ignored (firc always accepts coefficients). After addr NTAPS-1: PushCoef=0, LoadDone=1 for one cycle -> STREAM.
- Mutual exclusion: PushCoef and PushIn are never 1 in the same cycle.
- CfgLoad outside WAIT_CFG/STREAM: ignored; no queuing.
- CfgWr during LOAD: allowed. The bank is read at push time, so a write to an address not yet pushed takes effect in this load. A write and a push of the same address in the same cycle push the old value.
- Reset mid-LOAD or mid-handshake: all outputs drop asynchronously, state WAIT_CFG, FIFO contents lost, shadow bank zeroed.

Test Plan:
- Reset, then 5 samples (i=1..5) with no CfgLoad -> PushIn stays 0; InReady=1; count=5. CfgLoad -> PushCoef high 16 cycles addr 0..15, LoadDone pulse, then PushIn 5 back-to-back cycles SampI=SampQ=1..5.
- Write shadow[k]={k+100,k+200}, k=0..15, then CfgLoad -> CoefAddr=k with CoefI=k+100, CoefQ=k+200 on consecutive cycles; Busy=1 throughout.
- STREAM with StopIn=1 for 3 cycles while presenting sample 7 -> PushIn, SampI=7 held 3 cycles; consumed on the first StopIn=0 edge; no duplicate and no loss.
- Fill with 8 samples while StopIn=1 -> InReady=0 after the 8th; a 9th sample with InValid=1 is not accepted. Release StopIn -> 8 samples out in order, then InReady=1.
- CfgLoad while sample 3 is stalled by StopIn -> DRAIN holds PushIn until StopIn falls. LOAD starts the cycle after PushIn=0; samples 4.. resume after LoadDone; PushIn&PushCoef never both 1.
- Assert Reset_n=0 at LOAD addr 6 -> PushCoef, PushIn, Busy and LoadDone go 0 immediately; after release, state WAIT_CFG and a sample pushed is not forwarded.
